mod_cfg_sequencer: RTL and testbench
====================================

Name: mod_cfg_sequencer

Overview:
Controller that sequences the configurable AM/FM modulator datapath (DDS → CIC compensator → CIC interpolator → FM/AM modulator).
- Generates the sample-rate val_in strobe.
- Holds shadow and active copies of all modulation parameters and commits them atomically on a sample boundary.
- On a structural change (mode or source), flushes the filter chain with a datapath reset and mutes the output until the pipeline has settled.

Parameters:
- DIV, 8, clock cycles per input sample; val_in strobe period (≥2).
- FLUSH_CYC, 4, cycles dp_rst is held high during a flush (≥1).
- SETTLE_SAMPLES, 32, dp_val_out pulses counted before unmute (≥1); covers compensator plus CIC latency.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  shadow-register write strobe
- wr_addr  in  3  0=frec_mod, 1=frec_por, 2=im_am, 3=im_fm, 4=ctrl; 5–7 ignored
- wr_data  in  24  write data; 16-bit registers take [15:0]; ctrl takes [3:0] = {c_comp_dac, c_source[1:0], c_fm_am}
- commit  in  1  single-cycle request to apply shadow → active
- dp_val_out  in  1  datapath output-valid, counted during settle
- val_in  out  1  one-cycle sample strobe to the datapath
- dp_rst  out  1  datapath reset request (ORed with rst at top level)
- frec_mod, frec_por  out  24  active values
- im_am, im_fm  out  16  active values
- c_fm_am  out  1  active value
- c_source  out  2  active value
- c_comp_dac  out  1  active value
- mute  out  1  output gate; 1 = force DAC word to 0
- busy  out  1  commit in progress (state ≠ IDLE)

Behaviour:
- Reset (async, rst=1):
  - All shadow and active registers → 0; tick counter → 0; val_in=0; dp_rst=0.
  - state=SETTLE, settle count 0, mute=1, busy=1, pending=0.
- Tick counter:
  - Counts 0..DIV-1 and wraps.
  - val_in=1 exactly in cycles where cnt==DIV-1 and state≠FLUSH.
  - In FLUSH the counter is held at 0.
- Shadow registers:
  - Written on wr_en in any state, one cycle, no effect on active outputs.
  - Write to addr 5–7: no-op.
- States: IDLE, WAIT_TICK, FLUSH, SETTLE.
  - IDLE: commit → WAIT_TICK.
  - WAIT_TICK: on the cycle with cnt==DIV-1, all active registers ← shadow at that clock edge. The strobe in that cycle still carries the old configuration; the next strobe uses the new one.
    - If shadow {c_fm_am, c_source} ≠ active → FLUSH with flush count 0.
    - Otherwise → IDLE. Frequency, index and c_comp_dac changes never mute.
  - FLUSH: dp_rst=1, mute=1 for exactly FLUSH_CYC cycles, then → SETTLE with count 0.
  - SETTLE: mute=1; count each dp_val_out=1 cycle; val_in runs normally.
    - On the SETTLE_SAMPLES-th pulse, the next state is IDLE and mute=0 from the following cycle.
- mute and busy are registered outputs, decoded from the state.
- commit while busy:
  - Latched into a 1-bit pending flag; multiple commits collapse into one.
  - On the transition into IDLE with pending=1, go directly to WAIT_TICK and clear pending. Shadow values sampled at that later tick are the ones applied.
- Simultaneous wr_en and the apply edge: the write is not included in the apply; it stays in shadow for a later commit.
- Simultaneous commit and the entry into IDLE: treated as pending, so there is no lost commit.
- Reset mid-FLUSH or mid-SETTLE: the async reset wins; the block restarts in SETTLE with mute=1.
- Latency:
  - commit → active outputs update within DIV+1 cycles.
  - Structural change → unmute no earlier than FLUSH_CYC cycles plus SETTLE_SAMPLES datapath outputs.

Optional Feature:
MODSEQ_READBACK_EN
- Defined: adds input rd_addr[2:0] and output rd_data[23:0], a combinational read of the active registers using the write map. The ctrl register reads zero-extended; unused addresses read 0.
- Undefined: neither port exists; behaviour is otherwise identical.

Decomposition:
- Package mod_seq_pkg:
  - Address constants: ADDR_FREC_MOD … ADDR_CTRL.
  - Ctrl bit positions.
  - State enum typedef.
  - Register width constants: 24 for frequencies, 16 for indices.
- Sub-module: sample_tick_gen (DIV counter, hold input, val_in and cnt==DIV-1 outputs).

Test Plan (DIV=8, FLUSH_CYC=4, SETTLE_SAMPLES=32):
- Reset release, datapath model returning dp_val_out once per val_in → val_in every 8 cycles; mute=1 until the 32nd dp_val_out, then mute=0 and busy=0.
- Write frec_por=24'h100000, commit in IDLE → frec_por changes on the edge after the next cnt==7; mute stays 0; dp_rst never asserted.
- Write ctrl=4'b0011 (FM, ramp source), commit → active update at the tick, then dp_rst=1 for exactly 4 cycles with no val_in. mute=1 through 32 dp_val_out pulses, then cleared.
- Two commits during SETTLE, with im_am written to 16'h4000 between them → exactly one extra apply after IDLE, carrying 16'h4000.
- wr_en to frec_mod on the exact apply edge → old shadow value applied; the new value appears only after the next commit.
- rst pulse during FLUSH cycle 2 → dp_rst=0 and all active registers 0 immediately; state SETTLE, mute=1.

Source files
------------

// File: rtl/mod_cfg_sequencer_pkg.sv
// Shared types and constants for the modulator configuration sequencer:
// register map, ctrl bit layout, register widths and FSM state encoding.
package mod_seq_pkg;

    localparam int FREQ_W = 24;
    localparam int IDX_W  = 16;
    localparam int CTRL_W = 4;

    localparam logic [2:0] ADDR_FREC_MOD = 3'd0;
    localparam logic [2:0] ADDR_FREC_POR = 3'd1;
    localparam logic [2:0] ADDR_IM_AM    = 3'd2;
    localparam logic [2:0] ADDR_IM_FM    = 3'd3;
    localparam logic [2:0] ADDR_CTRL     = 3'd4;

    localparam int CTRL_FM_AM    = 0;
    localparam int CTRL_SRC_LSB  = 1;
    localparam int CTRL_COMP_DAC = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_TICK,
        ST_FLUSH,
        ST_SETTLE
    } seq_state_t;

endpackage

// File: rtl/mod_cfg_sequencer_sample_tick_gen.sv
// Sample-rate strobe generator: counts 0..DIV-1, strobes on the last count,
// and parks the counter at zero while i_hold is asserted.
module sample_tick_gen #(
    parameter int DIV = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_hold,
    output logic o_val_in,
    output logic o_last
);

    localparam int               CNT_W    = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_hold || (r_cnt == CNT_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_last   = (r_cnt == CNT_LAST);
    assign o_val_in = o_last && !i_hold;

endmodule

// File: rtl/mod_cfg_sequencer.sv
// Modulator configuration sequencer: shadow/active parameter commit on a sample
// boundary, datapath flush and muted settle on mode/source change.
// Optional combinational readback of the active registers: MODSEQ_READBACK_EN.
//
// state     | meaning
// IDLE      | active config stable, output live
// WAIT_TICK | commit accepted, waiting for the sample boundary to apply
// FLUSH     | datapath held in reset after a mode/source change
// SETTLE    | output muted until the filter chain has produced fresh samples
module mod_cfg_sequencer
    import mod_seq_pkg::*;
#(
    parameter int DIV            = 8,
    parameter int FLUSH_CYC      = 4,
    parameter int SETTLE_SAMPLES = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [2:0]        wr_addr,
    input  logic [FREQ_W-1:0] wr_data,
    input  logic              commit,
    input  logic              dp_val_out,
`ifdef MODSEQ_READBACK_EN
    input  logic [2:0]        rd_addr,
    output logic [FREQ_W-1:0] rd_data,
`endif
    output logic              val_in,
    output logic              dp_rst,
    output logic [FREQ_W-1:0] frec_mod,
    output logic [FREQ_W-1:0] frec_por,
    output logic [IDX_W-1:0]  im_am,
    output logic [IDX_W-1:0]  im_fm,
    output logic              c_fm_am,
    output logic [1:0]        c_source,
    output logic              c_comp_dac,
    output logic              mute,
    output logic              busy
);

    localparam int               FL_W     = $clog2(FLUSH_CYC + 1);
    localparam logic [FL_W-1:0]  FL_LOAD  = FL_W'(FLUSH_CYC - 1);
    localparam int               SET_W    = $clog2(SETTLE_SAMPLES + 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_SAMPLES - 1);

    seq_state_t        r_state, w_state_nxt;
    logic              r_pending, w_pending_nxt;
    logic [FL_W-1:0]   r_flush_cnt, w_flush_nxt;
    logic [SET_W-1:0]  r_settle_cnt, w_settle_nxt;
    logic              r_mute, r_busy, r_dp_rst;
    logic              w_tick_last, w_apply, w_struct_chg, w_to_idle;

    logic [FREQ_W-1:0] r_sh_frec_mod, r_sh_frec_por, r_frec_mod, r_frec_por;
    logic [IDX_W-1:0]  r_sh_im_am, r_sh_im_fm, r_im_am, r_im_fm;
    logic [CTRL_W-1:0] r_sh_ctrl, r_ctrl;

    sample_tick_gen #(.DIV(DIV)) u_tick (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_hold   (r_state == ST_FLUSH),
        .o_val_in (val_in),
        .o_last   (w_tick_last)
    );

    assign w_apply      = (r_state == ST_WAIT_TICK) && w_tick_last;
    assign w_struct_chg = {r_sh_ctrl[CTRL_SRC_LSB +: 2], r_sh_ctrl[CTRL_FM_AM]}
                       != {r_ctrl[CTRL_SRC_LSB +: 2], r_ctrl[CTRL_FM_AM]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh_frec_mod <= '0;
            r_sh_frec_por <= '0;
            r_sh_im_am    <= '0;
            r_sh_im_fm    <= '0;
            r_sh_ctrl     <= '0;
        end else if (wr_en) begin
            case (wr_addr)
                ADDR_FREC_MOD: r_sh_frec_mod <= wr_data;
                ADDR_FREC_POR: r_sh_frec_por <= wr_data;
                ADDR_IM_AM:    r_sh_im_am    <= wr_data[IDX_W-1:0];
                ADDR_IM_FM:    r_sh_im_fm    <= wr_data[IDX_W-1:0];
                ADDR_CTRL:     r_sh_ctrl     <= wr_data[CTRL_W-1:0];
                default:       ;
            endcase
        end
    end

    // A write landing on the apply edge stays in shadow: active samples the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frec_mod <= '0;
            r_frec_por <= '0;
            r_im_am    <= '0;
            r_im_fm    <= '0;
            r_ctrl     <= '0;
        end else if (w_apply) begin
            r_frec_mod <= r_sh_frec_mod;
            r_frec_por <= r_sh_frec_por;
            r_im_am    <= r_sh_im_am;
            r_im_fm    <= r_sh_im_fm;
            r_ctrl     <= r_sh_ctrl;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        w_flush_nxt   = r_flush_cnt;
        w_settle_nxt  = r_settle_cnt;
        w_to_idle     = 1'b0;
        if (commit && (r_state != ST_IDLE)) w_pending_nxt = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (commit) w_state_nxt = ST_WAIT_TICK;
            end
            ST_WAIT_TICK: begin
                if (w_tick_last) begin
                    if (w_struct_chg) begin
                        w_state_nxt = ST_FLUSH;
                        w_flush_nxt = FL_LOAD;
                    end else begin
                        w_to_idle = 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                if (r_flush_cnt == '0) begin
                    w_state_nxt  = ST_SETTLE;
                    w_settle_nxt = '0;
                end else begin
                    w_flush_nxt = r_flush_cnt - FL_W'(1);
                end
            end
            ST_SETTLE: begin
                if (dp_val_out) begin
                    if (r_settle_cnt == SET_LAST) w_to_idle = 1'b1;
                    else w_settle_nxt = r_settle_cnt + SET_W'(1);
                end
            end
            default: w_state_nxt = ST_SETTLE;
        endcase
        // A commit seen while busy (including this very cycle) re-arms instead of idling.
        if (w_to_idle) begin
            if (w_pending_nxt) begin
                w_state_nxt   = ST_WAIT_TICK;
                w_pending_nxt = 1'b0;
            end else begin
                w_state_nxt = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_SETTLE;
            r_pending    <= 1'b0;
            r_flush_cnt  <= '0;
            r_settle_cnt <= '0;
            r_mute       <= 1'b1;
            r_busy       <= 1'b1;
            r_dp_rst     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pending    <= w_pending_nxt;
            r_flush_cnt  <= w_flush_nxt;
            r_settle_cnt <= w_settle_nxt;
            r_mute       <= (w_state_nxt == ST_FLUSH) || (w_state_nxt == ST_SETTLE);
            r_busy       <= (w_state_nxt != ST_IDLE);
            r_dp_rst     <= (w_state_nxt == ST_FLUSH);
        end
    end

`ifdef MODSEQ_READBACK_EN
    always_comb begin
        rd_data = '0;
        case (rd_addr)
            ADDR_FREC_MOD: rd_data = r_frec_mod;
            ADDR_FREC_POR: rd_data = r_frec_por;
            ADDR_IM_AM:    rd_data = {{(FREQ_W-IDX_W){1'b0}}, r_im_am};
            ADDR_IM_FM:    rd_data = {{(FREQ_W-IDX_W){1'b0}}, r_im_fm};
            ADDR_CTRL:     rd_data = {{(FREQ_W-CTRL_W){1'b0}}, r_ctrl};
            default:       rd_data = '0;
        endcase
    end
`endif

    assign dp_rst     = r_dp_rst;
    assign mute       = r_mute;
    assign busy       = r_busy;
    assign frec_mod   = r_frec_mod;
    assign frec_por   = r_frec_por;
    assign im_am      = r_im_am;
    assign im_fm      = r_im_fm;
    assign c_fm_am    = r_ctrl[CTRL_FM_AM];
    assign c_source   = r_ctrl[CTRL_SRC_LSB +: 2];
    assign c_comp_dac = r_ctrl[CTRL_COMP_DAC];

endmodule

// File: tb/tb_mod_cfg_sequencer.sv
// Directed self-checking bench for mod_cfg_sequencer (DIV=8, FLUSH_CYC=4, SETTLE_SAMPLES=32).
module tb_mod_cfg_sequencer;
    import mod_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst, wr_en, commit, dp_val_out;
    logic [2:0]  wr_addr;
    logic [23:0] wr_data;
    logic        val_in, dp_rst, c_fm_am, c_comp_dac, mute, busy;
    logic [23:0] frec_mod, frec_por;
    logic [15:0] im_am, im_fm;
    logic [1:0]  c_source;
`ifdef MODSEQ_READBACK_EN
    logic [2:0]  rd_addr;
    logic [23:0] rd_data;
`endif

    int checks   = 0;
    int failures = 0;

    mod_cfg_sequencer #(.DIV(8), .FLUSH_CYC(4), .SETTLE_SAMPLES(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .commit     (commit),
        .dp_val_out (dp_val_out),
`ifdef MODSEQ_READBACK_EN
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
`endif
        .val_in     (val_in),
        .dp_rst     (dp_rst),
        .frec_mod   (frec_mod),
        .frec_por   (frec_por),
        .im_am      (im_am),
        .im_fm      (im_fm),
        .c_fm_am    (c_fm_am),
        .c_source   (c_source),
        .c_comp_dac (c_comp_dac),
        .mute       (mute),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Datapath model: one output sample per input strobe, one cycle later.
    always @(posedge clk or posedge rst) begin
        if (rst) dp_val_out <= 1'b0;
        else     dp_val_out <= val_in & ~dp_rst;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [23:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic pulse_commit();
        commit = 1'b1;
        step();
        commit = 1'b0;
    endtask

    task automatic wait_unmute(output int pulses, output bit saw_rst);
        pulses = 0; saw_rst = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (mute === 1'b0) break;
            if (dp_val_out === 1'b1) pulses++;
            if (dp_rst === 1'b1) saw_rst = 1'b1;
            step();
        end
    endtask

    task automatic test_reset();
        int bad; int pulses;
        rst = 1'b1; wr_en = 1'b0; commit = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (3) step();
        checks++;
        if ({val_in, dp_rst, mute, busy} !== 4'b0011) begin
            failures++;
            $display("FAIL reset_ctl got={val_in,dp_rst,mute,busy}=%b exp=0011", {val_in, dp_rst, mute, busy});
        end
        checks++;
        if ({frec_mod, frec_por, im_am, im_fm, c_fm_am, c_source, c_comp_dac} !== 84'd0) begin
            failures++;
            $display("FAIL reset_active got frec_mod=%h frec_por=%h im_am=%h exp all zero", frec_mod, frec_por, im_am);
        end
        rst = 1'b0;
        bad = 0; pulses = 0;
        for (int i = 1; i <= 400; i++) begin
            step();
            if (i <= 32 && val_in !== ((i % 8) == 7)) bad++;
            if (mute === 1'b0) break;
            if (dp_val_out === 1'b1) pulses++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL val_in_period got %0d misplaced strobes exp 0", bad);
        end
        checks++;
        if (mute !== 1'b0 || pulses != 32) begin
            failures++;
            $display("FAIL reset_settle got mute=%b pulses=%0d exp mute=0 pulses=32", mute, pulses);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got %b exp 0", busy);
        end
    endtask

    task automatic test_freq_commit();
        int lat; bit prev; bit found; int bad;
        write_reg(ADDR_FREC_POR, 24'h100000);
        checks++;
        if (frec_por !== 24'h0) begin
            failures++;
            $display("FAIL shadow_isolation got frec_por=%h exp 0", frec_por);
        end
        pulse_commit();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL commit_busy got %b exp 1", busy);
        end
        lat = 1; prev = 1'b0; found = 1'b0; bad = 0;
        for (int i = 0; i < 12; i++) begin
            if (mute !== 1'b0 || dp_rst !== 1'b0) bad++;
            if (frec_por === 24'h100000) begin found = 1'b1; break; end
            prev = val_in;
            step();
            lat++;
        end
        checks++;
        if (!found || prev !== 1'b1 || lat > 9) begin
            failures++;
            $display("FAIL freq_apply got found=%b prev_val_in=%b latency=%0d exp 1 1 <=9", found, prev, lat);
        end
        checks++;
        if (bad != 0 || busy !== 1'b0 || frec_mod !== 24'h0) begin
            failures++;
            $display("FAIL freq_no_mute got bad=%0d busy=%b frec_mod=%h exp 0 0 0", bad, busy, frec_mod);
        end
`ifdef MODSEQ_READBACK_EN
        rd_addr = ADDR_FREC_POR;
        #1;
        checks++;
        if (rd_data !== 24'h100000) begin
            failures++;
            $display("FAIL readback got %h exp 100000", rd_data);
        end
`endif
    endtask

    task automatic test_struct_commit();
        int n; int bad; int pulses; bit saw_rst;
        write_reg(ADDR_CTRL, 24'h3);
        pulse_commit();
        for (int i = 0; i < 12; i++) begin
            if (c_fm_am === 1'b1) break;
            step();
        end
        checks++;
        if ({c_fm_am, c_source, c_comp_dac} !== 4'b1010) begin
            failures++;
            $display("FAIL struct_apply got {fm_am,src,dac}=%b exp 1010", {c_fm_am, c_source, c_comp_dac});
        end
        n = 0; bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (dp_rst !== 1'b1) break;
            n++;
            if (val_in !== 1'b0 || mute !== 1'b1) bad++;
            step();
        end
        checks++;
        if (n != 4 || bad != 0) begin
            failures++;
            $display("FAIL flush_len got cycles=%0d bad=%0d exp 4 0", n, bad);
        end
        checks++;
        if (mute !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL settle_entry got mute=%b busy=%b exp 1 1", mute, busy);
        end
        wait_unmute(pulses, saw_rst);
        checks++;
        if (mute !== 1'b0 || pulses != 32 || saw_rst) begin
            failures++;
            $display("FAIL struct_settle got mute=%b pulses=%0d dp_rst_seen=%b exp 0 32 0", mute, pulses, saw_rst);
        end
    endtask

    task automatic test_pending();
        int n;
        write_reg(ADDR_CTRL, 24'h0);
        pulse_commit();
        for (int i = 0; i < 12; i++) begin if (dp_rst === 1'b1) break; step(); end
        for (int i = 0; i < 10; i++) begin if (dp_rst === 1'b0) break; step(); end
        repeat (3) step();
        pulse_commit();
        write_reg(ADDR_IM_AM, 24'h004000);
        pulse_commit();
        checks++;
        if (im_am !== 16'h0 || mute !== 1'b1) begin
            failures++;
            $display("FAIL pending_hold got im_am=%h mute=%b exp 0 1", im_am, mute);
        end
        for (int i = 0; i < 400; i++) begin if (mute === 1'b0) break; step(); end
        checks++;
        if (mute !== 1'b0 || busy !== 1'b1 || im_am !== 16'h0) begin
            failures++;
            $display("FAIL pending_rearm got mute=%b busy=%b im_am=%h exp 0 1 0", mute, busy, im_am);
        end
        for (int i = 0; i < 12; i++) begin if (busy === 1'b0) break; step(); end
        checks++;
        if (busy !== 1'b0 || im_am !== 16'h4000) begin
            failures++;
            $display("FAIL pending_apply got busy=%b im_am=%h exp 0 4000", busy, im_am);
        end
        n = 0;
        for (int i = 0; i < 24; i++) begin step(); if (busy !== 1'b0) n++; end
        checks++;
        if (n != 0) begin
            failures++;
            $display("FAIL pending_single got %0d busy cycles exp 0", n);
        end
    endtask

    task automatic test_wr_on_apply();
        bit found;
        write_reg(ADDR_FREC_MOD, 24'h000AAA);
        pulse_commit();
        found = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (val_in === 1'b1) begin
                wr_en = 1'b1; wr_addr = ADDR_FREC_MOD; wr_data = 24'h000BBB;
                step();
                wr_en = 1'b0;
                found = 1'b1;
                break;
            end
            step();
        end
        checks++;
        if (!found || frec_mod !== 24'h000AAA || busy !== 1'b0) begin
            failures++;
            $display("FAIL wr_on_apply got found=%b frec_mod=%h busy=%b exp 1 000aaa 0", found, frec_mod, busy);
        end
        repeat (10) step();
        checks++;
        if (frec_mod !== 24'h000AAA) begin
            failures++;
            $display("FAIL wr_stays_shadow got %h exp 000aaa", frec_mod);
        end
        pulse_commit();
        for (int i = 0; i < 12; i++) begin if (busy === 1'b0) break; step(); end
        checks++;
        if (busy !== 1'b0 || frec_mod !== 24'h000BBB) begin
            failures++;
            $display("FAIL wr_later_commit got busy=%b frec_mod=%h exp 0 000bbb", busy, frec_mod);
        end
    endtask

    task automatic test_reset_mid_flush();
        int pulses; bit saw_rst;
        write_reg(ADDR_CTRL, 24'h5);
        pulse_commit();
        for (int i = 0; i < 12; i++) begin if (dp_rst === 1'b1) break; step(); end
        step();
        checks++;
        if (dp_rst !== 1'b1) begin
            failures++;
            $display("FAIL flush_cycle2 got dp_rst=%b exp 1", dp_rst);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({dp_rst, mute, busy, val_in} !== 4'b0110) begin
            failures++;
            $display("FAIL midflush_ctl got {dp_rst,mute,busy,val_in}=%b exp 0110", {dp_rst, mute, busy, val_in});
        end
        checks++;
        if ({frec_mod, frec_por, im_am, im_fm, c_fm_am, c_source, c_comp_dac} !== 84'd0) begin
            failures++;
            $display("FAIL midflush_active got frec_mod=%h frec_por=%h im_am=%h ctrl=%b exp all zero",
                     frec_mod, frec_por, im_am, {c_comp_dac, c_source, c_fm_am});
        end
        step();
        rst = 1'b0;
        wait_unmute(pulses, saw_rst);
        checks++;
        if (mute !== 1'b0 || pulses != 32 || saw_rst || c_fm_am !== 1'b0) begin
            failures++;
            $display("FAIL midflush_restart got mute=%b pulses=%0d dp_rst_seen=%b fm_am=%b exp 0 32 0 0",
                     mute, pulses, saw_rst, c_fm_am);
        end
    endtask

    initial begin
`ifdef MODSEQ_READBACK_EN
        rd_addr = '0;
`endif
        test_reset();
        test_freq_commit();
        test_struct_commit();
        test_pending();
        test_wr_on_apply();
        test_reset_mid_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
